atm_ledger: RTL and testbench

//  Multi-account ATM ledger; parametrised successor of the single-balance deposit/withdraw counter.

---
 rtl/atm_ledger.sv | 156 +++++++++++++++
 tb/tb_atm_ledger.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger.sv
// Multi-account ATM ledger: PIN-checked login with lockout, range-checked deposit/withdraw
// on the active account, and automatic logout of idle sessions.
module atm_ledger #(
    parameter int                          BAL_W     = 8,
    parameter int                          NUM_ACCT  = 4,
    parameter int                          PIN_W     = 4,
    parameter logic [NUM_ACCT*PIN_W-1:0]   PIN_INIT  = 16'h4321,
    parameter logic [BAL_W-1:0]            INIT_BAL  = 8'd50,
    parameter int                          MAX_BAL   = 255,
    parameter int                          MAX_TRIES = 3,
    parameter int                          TIMEOUT   = 1000,
    localparam int                         AW        = $clog2(NUM_ACCT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       acct_sel,
    input  logic [PIN_W-1:0]    pin_in,
    input  logic                login,
    input  logic                logout,
    input  logic [BAL_W-1:0]    amount,
    input  logic                deposit,
    input  logic                withdraw,
    output logic [BAL_W-1:0]    balance,
    output logic                logged_in,
    output logic [NUM_ACCT-1:0] acct_locked,
    output logic                err_pin,
    output logic                err_funds,
    output logic                err_full,
    output logic                err_conflict
);

    localparam int              TW         = $clog2(TIMEOUT);
    localparam int              CW         = $clog2(MAX_TRIES + 1);
    localparam logic [BAL_W:0]  MAX_SUM    = (BAL_W+1)'(MAX_BAL);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   TRIES_LAST = CW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, SESSION} state_t;
    typedef enum logic [2:0] {TX_NONE, TX_DEP, TX_WD, TX_FULL, TX_FUNDS, TX_CONFLICT} tx_t;

    state_t           state;
    tx_t              tx;
    logic [AW-1:0]    sel_q;
    logic [PIN_W-1:0] pin_q;
    logic [TW-1:0]    timer;
    logic [BAL_W-1:0] bal_mem [NUM_ACCT];
    logic [CW-1:0]    tries   [NUM_ACCT];
    logic [PIN_W-1:0] pin_tab [NUM_ACCT];

    logic [BAL_W-1:0] cur_bal;
    logic [BAL_W:0]   dep_sum;
    logic [BAL_W-1:0] wd_diff;

    for (genvar k = 0; k < NUM_ACCT; k++) begin : g_pin
        assign pin_tab[k] = PIN_INIT[k*PIN_W +: PIN_W];
    end

    // The sum is one bit wider so an overflowing deposit is seen rather than wrapped.
    assign cur_bal = bal_mem[sel_q];
    assign dep_sum = {1'b0, cur_bal} + {1'b0, amount};
    assign wd_diff = cur_bal - amount;

    always_comb begin
        // NOTE: default first, so no branch leaves tx unassigned and no latch is inferred.
        tx = TX_NONE;
        if (deposit && withdraw)
            tx = TX_CONFLICT;
        else if (deposit)
            tx = (dep_sum > MAX_SUM) ? TX_FULL : TX_DEP;
        else if (withdraw)
            tx = (amount > cur_bal) ? TX_FUNDS : TX_WD;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees the pre-edge values.
        if (!reset) begin
            state        <= IDLE;
            sel_q        <= '0;
            pin_q        <= '0;
            timer        <= '0;
            acct_locked  <= '0;
            balance      <= '0;
            logged_in    <= 1'b0;
            err_pin      <= 1'b0;
            err_funds    <= 1'b0;
            err_full     <= 1'b0;
            err_conflict <= 1'b0;
            // NOTE: the balance file is reset on purpose: every account restarts at INIT_BAL.
            for (int k = 0; k < NUM_ACCT; k++) begin
                bal_mem[k] <= INIT_BAL;
                tries[k]   <= '0;
            end
        end else begin
            err_pin      <= 1'b0;
            err_funds    <= 1'b0;
            err_full     <= 1'b0;
            err_conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (login) begin
                        sel_q <= acct_sel;
                        pin_q <= pin_in;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (acct_locked[sel_q]) begin
                        err_pin <= 1'b1;
                        state   <= IDLE;
                    end else if (pin_q == pin_tab[sel_q]) begin
                        tries[sel_q] <= '0;
                        timer        <= '0;
                        balance      <= cur_bal;
                        logged_in    <= 1'b1;
                        state        <= SESSION;
                    end else begin
                        tries[sel_q] <= tries[sel_q] + 1'b1;
                        if (tries[sel_q] == TRIES_LAST)
                            acct_locked[sel_q] <= 1'b1;
                        err_pin <= 1'b1;
                        state   <= IDLE;
                    end
                end
                SESSION: begin
                    // Logout beats any same-cycle transaction; a transaction beats the timeout.
                    if (logout || (!deposit && !withdraw && timer == TIMER_LAST)) begin
                        balance   <= '0;
                        logged_in <= 1'b0;
                        timer     <= '0;
                        state     <= IDLE;
                    end else if (deposit || withdraw) begin
                        timer <= '0;
                        case (tx)
                            TX_DEP: begin
                                bal_mem[sel_q] <= dep_sum[BAL_W-1:0];
                                balance        <= dep_sum[BAL_W-1:0];
                            end
                            TX_WD: begin
                                bal_mem[sel_q] <= wd_diff;
                                balance        <= wd_diff;
                            end
                            TX_FULL:     err_full     <= 1'b1;
                            TX_FUNDS:    err_funds    <= 1'b1;
                            TX_CONFLICT: err_conflict <= 1'b1;
                            default:     ;
                        endcase
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_ledger.sv
// Bench for atm_ledger: directed scenarios followed by random traffic, every cycle compared
// against a behavioural account-book model.
module tb_atm_ledger;

    localparam int          BAL_W     = 8;
    localparam int          NUM_ACCT  = 4;
    localparam int          PIN_W     = 4;
    localparam int          MAX_BAL   = 255;
    localparam int          MAX_TRIES = 3;
    localparam int          TIMEOUT   = 8;
    localparam int          INIT_BAL  = 50;
    // Account 0..3 hold PINs 4,3,2,1.
    localparam logic [15:0] PIN_TABLE = 16'h1234;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          acct_sel;
    logic [PIN_W-1:0]    pin_in;
    logic                login, logout, deposit, withdraw;
    logic [BAL_W-1:0]    amount;
    logic [BAL_W-1:0]    balance;
    logic                logged_in;
    logic [NUM_ACCT-1:0] acct_locked;
    logic                err_pin, err_funds, err_full, err_conflict;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the account book plus where the customer is in the login flow.
    typedef enum int {M_IDLE, M_CHECK, M_SESSION} phase_t;
    phase_t m_phase;
    int     m_bal   [NUM_ACCT];
    int     m_fails [NUM_ACCT];
    bit     m_lock  [NUM_ACCT];
    int     m_acct, m_pin, m_idle;
    bit     e_pin, e_funds, e_full, e_conf;

    always #5 clk = ~clk;

    atm_ledger #(
        .BAL_W(BAL_W), .NUM_ACCT(NUM_ACCT), .PIN_W(PIN_W), .PIN_INIT(PIN_TABLE),
        .INIT_BAL(8'd50), .MAX_BAL(MAX_BAL), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .acct_sel(acct_sel), .pin_in(pin_in),
        .login(login), .logout(logout), .amount(amount), .deposit(deposit),
        .withdraw(withdraw), .balance(balance), .logged_in(logged_in),
        .acct_locked(acct_locked), .err_pin(err_pin), .err_funds(err_funds),
        .err_full(err_full), .err_conflict(err_conflict)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pin_of(input int k);
        logic [15:0] t;
        t = PIN_TABLE;
        return int'(t[k*PIN_W +: PIN_W]);
    endfunction

    function automatic logic [NUM_ACCT-1:0] lock_vec();
        logic [NUM_ACCT-1:0] v;
        for (int k = 0; k < NUM_ACCT; k++) v[k] = m_lock[k];
        return v;
    endfunction

    // Apply the rules to the inputs present at this clock edge.
    task automatic model_update();
        e_pin = 0; e_funds = 0; e_full = 0; e_conf = 0;
        if (!reset) begin
            for (int k = 0; k < NUM_ACCT; k++) begin
                m_bal[k] = INIT_BAL; m_fails[k] = 0; m_lock[k] = 0;
            end
            m_phase = M_IDLE;
            m_idle  = 0;
        end else if (m_phase == M_IDLE) begin
            if (login) begin
                m_acct  = int'(acct_sel);
                m_pin   = int'(pin_in);
                m_phase = M_CHECK;
            end
        end else if (m_phase == M_CHECK) begin
            if (m_lock[m_acct]) begin
                e_pin = 1; m_phase = M_IDLE;
            end else if (m_pin == pin_of(m_acct)) begin
                m_fails[m_acct] = 0; m_idle = 0; m_phase = M_SESSION;
            end else begin
                m_fails[m_acct]++;
                if (m_fails[m_acct] >= MAX_TRIES) m_lock[m_acct] = 1;
                e_pin = 1; m_phase = M_IDLE;
            end
        end else begin
            if (logout) begin
                m_phase = M_IDLE;
            end else if (deposit || withdraw) begin
                m_idle = 0;
                if (deposit && withdraw)                        e_conf = 1;
                else if (deposit && m_bal[m_acct] + int'(amount) > MAX_BAL) e_full = 1;
                else if (deposit)                               m_bal[m_acct] += int'(amount);
                else if (int'(amount) > m_bal[m_acct])          e_funds = 1;
                else                                            m_bal[m_acct] -= int'(amount);
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) m_phase = M_IDLE;
            end
        end
    endtask

    task automatic compare_all();
        check("logged_in", logged_in, (m_phase == M_SESSION) ? 1 : 0);
        check("balance", balance, (m_phase == M_SESSION) ? m_bal[m_acct] : 0);
        check("acct_locked", acct_locked, lock_vec());
        check("err_pin", err_pin, e_pin);
        check("err_funds", err_funds, e_funds);
        check("err_full", err_full, e_full);
        check("err_conflict", err_conflict, e_conf);
    endtask

    // One clock: the model sees the same edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        login = 0; logout = 0; deposit = 0; withdraw = 0;
    endtask

    task automatic do_login(input int a, input int p);
        acct_sel = 2'(a); pin_in = 4'(p); login = 1;
        step();
        check("login_latency", logged_in, 0);
        step();
    endtask

    task automatic txn(input bit d, input bit w, input int amt);
        deposit = d; withdraw = w; amount = 8'(amt);
        step();
    endtask

    task automatic do_logout();
        logout = 1;
        step();
        check("logout", logged_in, 0);
    endtask

    initial begin
        reset = 0; acct_sel = 0; pin_in = 0; amount = 0;
        login = 0; logout = 0; deposit = 0; withdraw = 0;
        step();
        step();
        check("rst_locked", acct_locked, 0);
        check("rst_balance", balance, 0);
        reset = 1;

        // Login to account 1, then logout.
        do_login(1, 3);
        check("t1_logged_in", logged_in, 1);
        check("t1_balance", balance, 50);
        do_logout();

        // Deposit and withdraw down to exactly zero, then overdraw.
        do_login(0, 4);
        txn(1, 0, 100); check("t2_dep100", balance, 150);
        txn(0, 1, 150); check("t2_wd_all", balance, 0);
        txn(0, 1, 1);   check("t2_funds", err_funds, 1); check("t2_funds_bal", balance, 0);
        do_logout();

        // Fill to the top of the range.
        do_login(3, 1);
        txn(1, 0, 150); check("t3_bal200", balance, 200);
        txn(1, 0, 56);  check("t3_full", err_full, 1); check("t3_full_bal", balance, 200);
        txn(1, 0, 55);  check("t3_max", balance, 255); check("t3_no_full", err_full, 0);
        txn(1, 0, 0);   check("t3_zero_dep", balance, 255); check("t3_zero_nofull", err_full, 0);
        do_logout();

        // Lock account 2 with three bad PINs; only reset unlocks it.
        for (int i = 0; i < 3; i++) begin
            do_login(2, 0);
            check("t4_err_pin", err_pin, 1);
        end
        check("t4_locked", acct_locked, 4'b0100);
        do_login(2, 2);
        check("t4_locked_pin", err_pin, 1);
        check("t4_locked_out", logged_in, 0);
        reset = 0;
        step();
        reset = 1;
        check("t4_unlocked", acct_locked, 0);
        do_login(2, 2);
        check("t4_relogin", logged_in, 1);
        do_logout();

        // Conflicting requests and logout priority.
        do_login(1, 3);
        txn(1, 1, 10);
        check("t5_conflict", err_conflict, 1);
        check("t5_conflict_bal", balance, 50);
        logout = 1; deposit = 1; amount = 10;
        step();
        check("t5_logout_prio", logged_in, 0);
        do_login(1, 3);
        check("t5_bal_kept", balance, 50);
        do_logout();

        // Idle timeout and timer restart.
        do_login(0, 4);
        repeat (7) step();
        check("t6_7idle", logged_in, 1);
        txn(1, 0, 0);
        check("t6_restart", logged_in, 1);
        repeat (7) step();
        check("t6_7idle_again", logged_in, 1);
        step();
        check("t6_timeout", logged_in, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int a;
            reset    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            a        = $urandom_range(0, NUM_ACCT - 1);
            acct_sel = 2'(a);
            pin_in   = ($urandom_range(0, 99) < 80) ? 4'(pin_of(a)) : 4'($urandom_range(0, 15));
            login    = ($urandom_range(0, 99) < 20);
            logout   = ($urandom_range(0, 99) < 5);
            deposit  = ($urandom_range(0, 99) < 30);
            withdraw = ($urandom_range(0, 99) < 30);
            amount   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 60))
                                                  : 8'($urandom_range(0, 255));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
